cbr_ts_pacer: RTL and testbench

CBR_TS_PACER -- requirements
Module: cbr_ts_pacer

---
 rtl/cbr_ts_pacer.sv | 95 +++++++++
 tb/tb_cbr_ts_pacer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cbr_ts_pacer.sv
// cbr_ts_pacer: constant-rate TS byte pacer that sends video packets or inserted null packets.
// Defining CBR_PACER_STATS_EN adds the vid_pkt_cnt/null_pkt_cnt packet counters.
module cbr_ts_pacer #(
  parameter logic [12:0] BYTE_PERIOD = 13'd8,
  parameter logic [7:0]  PKT_LEN     = 8'd188
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic [12:0] fifo_rd_data_count,
  output logic        fifo_rd_en,
  output logic [7:0]  ts_data,
  output logic        ts_valid,
  output logic        ts_sync,
  output logic        ts_null,
  output logic        underrun,
  output logic        sync_err
`ifdef CBR_PACER_STATS_EN
  ,
  output logic [31:0] vid_pkt_cnt,
  output logic [31:0] null_pkt_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, VID, NUL} state_t;
  state_t      state_q;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d, null_byte, out_byte, s1_null_q, ts_data_q;
  logic        tick, cur_vid, s1_valid_q, s1_vid_q, s1_empty_q, s1_idx0_q;
  logic        ts_valid_q, ts_sync_q, ts_null_q, underrun_q, sync_err_q;
  // The packet type is chosen combinationally at the byte-0 tick so the read can issue in that same cycle
  always_comb begin
    tick      = cnt_q == '0;
    cur_vid   = idx_q == '0 ? fifo_rd_data_count >= {5'd0, PKT_LEN} : state_q == VID;
    cnt_d     = cnt_q == BYTE_PERIOD - 13'd1 ? '0 : cnt_q + 13'd1;
    idx_d     = !tick ? idx_q : idx_q == PKT_LEN - 8'd1 ? '0 : idx_q + 8'd1;
    null_byte = idx_q == 8'd0 ? 8'h47 : idx_q == 8'd1 ? 8'h1F : idx_q == 8'd3 ? 8'h10 : 8'hFF;
    out_byte  = !s1_vid_q ? s1_null_q : s1_empty_q ? 8'h00 : fifo_dout;
  end
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_vid_q   <= 1'b0;
      s1_empty_q <= 1'b0;
      s1_idx0_q  <= 1'b0;
      s1_null_q  <= '0;
      ts_data_q  <= '0;
      ts_valid_q <= 1'b0;
      ts_sync_q  <= 1'b0;
      ts_null_q  <= 1'b0;
      underrun_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_q    <= tick ? (cur_vid ? VID : NUL) : state_q;
      s1_valid_q <= tick;
      s1_vid_q   <= cur_vid;
      s1_empty_q <= fifo_empty;
      s1_idx0_q  <= idx_q == '0;
      s1_null_q  <= null_byte;
      ts_data_q  <= s1_valid_q ? out_byte : ts_data_q;
      ts_valid_q <= s1_valid_q;
      ts_sync_q  <= s1_valid_q & s1_idx0_q;
      ts_null_q  <= s1_valid_q & ~s1_vid_q;
      underrun_q <= s1_valid_q & s1_vid_q & s1_empty_q;
      sync_err_q <= s1_valid_q & s1_vid_q & s1_idx0_q & (out_byte != 8'h47);
    end
  end
  // Reset gates the outputs immediately, so pending pipeline stages never leak out
  assign fifo_rd_en = tick & cur_vid & ~rst;
  assign ts_data    = rst ? 8'h00 : ts_data_q;
  assign ts_valid   = ts_valid_q & ~rst;
  assign ts_sync    = ts_sync_q & ~rst;
  assign ts_null    = ts_null_q & ~rst;
  assign underrun   = underrun_q & ~rst;
  assign sync_err   = sync_err_q & ~rst;
`ifdef CBR_PACER_STATS_EN
  logic [31:0] vid_cnt_q, null_cnt_q;
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      vid_cnt_q  <= '0;
      null_cnt_q <= '0;
    end else if (ts_valid_q & ts_sync_q) begin
      vid_cnt_q  <= ts_null_q ? vid_cnt_q : vid_cnt_q + 32'd1;
      null_cnt_q <= ts_null_q ? null_cnt_q + 32'd1 : null_cnt_q;
    end
  end
  assign vid_pkt_cnt  = vid_cnt_q;
  assign null_pkt_cnt = null_cnt_q;
`endif
endmodule

// File: tb/tb_cbr_ts_pacer.sv
// tb_cbr_ts_pacer: bench for cbr_ts_pacer with a FIFO model and a slot-timeline reference model.
module tb_cbr_ts_pacer;
  localparam int BP = 8, PL = 188, PKT_CYC = BP * PL;
  logic        rd_clk = 1'b0, rst = 1'b1;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty = 1'b1;
  logic [12:0] fifo_rd_data_count = '0;
  logic        fifo_rd_en, ts_valid, ts_sync, ts_null, underrun, sync_err;
  logic [7:0]  ts_data;
  logic        force_empty = 1'b0, force_cnt_en = 1'b0;
  logic [12:0] force_cnt = '0;
  logic [7:0]  fq[$];
  int errors = 0, checks = 0;
  int n_vid = 0, n_null = 0, n_serr = 0, n_und = 0;

  typedef struct {int due; logic [7:0] b; logic sy, nu, ur, se;} exp_t;
  exp_t eq[$];
  exp_t e;
  int   cyc = 0, bi;
  logic pvid = 1'b0, tk;

  typedef struct {int pre; logic [7:0] first; int npk; int vid; int nul; int serr;} ph_t;
  ph_t tbl[3];

  cbr_ts_pacer #(.BYTE_PERIOD(13'd8), .PKT_LEN(8'd188)) dut (
    .rd_clk(rd_clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_data_count(fifo_rd_data_count), .fifo_rd_en(fifo_rd_en), .ts_data(ts_data),
    .ts_valid(ts_valid), .ts_sync(ts_sync), .ts_null(ts_null), .underrun(underrun), .sync_err(sync_err)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic upd();
    fifo_empty = force_empty || fq.size() == 0;
    fifo_rd_data_count = force_cnt_en ? force_cnt : 13'(fq.size());
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic load(int n, logic [7:0] first);
    for (int k = 0; k < n; k++) fq.push_back(k % PL == 0 ? first : 8'(k % PL - 1));
    upd();
  endtask

  function automatic logic [7:0] nul(int i);
    return i == 0 ? 8'h47 : i == 1 ? 8'h1F : i == 3 ? 8'h10 : 8'hFF;
  endfunction

  // Normal-mode FIFO: data appears the cycle after a read; reads while empty are ignored
  always @(posedge rd_clk) begin
    if (fifo_rd_en && !force_empty && fq.size() > 0) fifo_dout <= fq.pop_front();
    #1 upd();
  end

  // Reference: byte slot n of the run after reset starts at cycle n*BP and appears two cycles later
  always @(negedge rd_clk) begin
    if (rst) begin
      cyc = 0;
      eq.delete();
      chk("reset_outs", 32'({fifo_rd_en, ts_data, ts_valid, ts_sync, ts_null, underrun, sync_err}), 0);
    end else begin
      tk = cyc % BP == 0;
      bi = (cyc / BP) % PL;
      if (tk && bi == 0) pvid = fifo_rd_data_count >= 13'(PL);
      chk("rd_en", 32'(fifo_rd_en), 32'(tk && pvid));
      if (tk) begin
        e.due = cyc + 2;
        e.b   = pvid ? (fifo_empty ? 8'h00 : fq[0]) : nul(bi);
        e.sy  = bi == 0;
        e.nu  = !pvid;
        e.ur  = pvid && fifo_empty;
        e.se  = pvid && bi == 0 && e.b != 8'h47;
        eq.push_back(e);
      end
      if (eq.size() > 0 && eq[0].due == cyc) begin
        chk("ts_data", 32'(ts_data), 32'(eq[0].b));
        chk("ts_flags", 32'({ts_valid, ts_sync, ts_null, underrun, sync_err}),
            32'({1'b1, eq[0].sy, eq[0].nu, eq[0].ur, eq[0].se}));
        void'(eq.pop_front());
      end else begin
        chk("gap_flags", 32'({ts_valid, ts_sync, ts_null, underrun, sync_err}), 0);
      end
      if (ts_valid && ts_sync) begin
        if (ts_null) n_null++;
        else n_vid++;
      end
      if (ts_valid && sync_err) n_serr++;
      if (ts_valid && underrun) n_und++;
      cyc++;
    end
  end

  initial begin
    int v0, n0, s0, u0, k;
    tbl[0] = '{0,   8'h47, 3, 0, 3, 0};
    tbl[1] = '{376, 8'h47, 2, 2, 0, 0};
    tbl[2] = '{188, 8'h46, 1, 1, 0, 1};
    upd();
    step(5);
    chk("rst_valid", 32'(ts_valid), 0);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      fq.delete();
      load(tbl[p].pre, tbl[p].first);
      v0 = n_vid; n0 = n_null; s0 = n_serr;
      step(tbl[p].npk * PKT_CYC);
      chk($sformatf("ph%0d_vid", p), 32'(n_vid - v0), 32'(tbl[p].vid));
      chk($sformatf("ph%0d_null", p), 32'(n_null - n0), 32'(tbl[p].nul));
      chk($sformatf("ph%0d_serr", p), 32'(n_serr - s0), 32'(tbl[p].serr));
    end
    // Fill level below a packet at byte 0, raised mid-packet: null now, video next
    fq.delete();
    load(188, 8'h47);
    force_cnt_en = 1'b1; force_cnt = 13'd187; upd();
    v0 = n_vid; n0 = n_null;
    step(400);
    force_cnt = 13'd200; upd();
    step(PKT_CYC - 400 + 1);
    force_cnt_en = 1'b0; upd();
    step(PKT_CYC - 1);
    chk("midfill_null", 32'(n_null - n0), 1);
    chk("midfill_vid", 32'(n_vid - v0), 1);
    // Empty FIFO at byte 50 of a video packet
    fq.delete();
    load(188, 8'h47);
    v0 = n_vid; u0 = n_und;
    step(50 * BP);
    force_empty = 1'b1; upd();
    step(1);
    force_empty = 1'b0; upd();
    step(PKT_CYC - 50 * BP - 1);
    chk("und_vid", 32'(n_vid - v0), 1);
    chk("und_cnt", 32'(n_und - u0), 1);
    // Random fill levels, contents and underruns
    fq.delete(); upd();
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(0, 260);
      for (int i = 0; i < n; i++)
        fq.push_back(i == 0 && $urandom_range(0, 3) != 0 ? 8'h47 : 8'($urandom));
      upd();
      k = $urandom_range(0, PL - 1);
      step(k * BP);
      force_empty = 1'($urandom_range(0, 1)); upd();
      step(1);
      force_empty = 1'b0; upd();
      step(PKT_CYC - k * BP - 1);
    end
    // Reset in the middle of a packet
    fq.delete();
    load(188, 8'h47);
    step(100 * BP + 3);
    rst = 1'b1;
    step(1);
    chk("midrst_outs", 32'({fifo_rd_en, ts_data, ts_valid, ts_sync, ts_null, underrun, sync_err}), 0);
    step(2);
    rst = 1'b0;
    fq.delete(); upd();
    step(2);
    chk("post_rst_b0", 32'({ts_valid, ts_sync, ts_null, ts_data}), 32'({3'b111, 8'h47}));
    step(PKT_CYC);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
